adc_input_iq: RTL
=================

Name: adc_input_iq

Overview:
- Parametrised successor to the single-channel interleaved I/Q ADC front end.
- Drives the ADC conversion clock and the I/Q select line from the system clock.
- Compensates the ADC pipeline latency when assigning samples to channels.
- Converts the configurable input coding to signed, left-justified samples, pairs I/Q into one word, and buffers pairs in a FIFO ahead of an AXI-Stream master.
- Sits between the ADC pins and the downstream DSP/FFT stream chain.

Parameters:
- ADC_WIDTH, 10: ADC data bits.
- OUT_WIDTH, 16: per-channel output bits; must satisfy OUT_WIDTH >= ADC_WIDTH.
- CODING, 0: input coding. 0 = offset binary, 1 = two's complement.
- CLK_DIV, 2: clk cycles per adc_clk half-period (>= 1).
- ADC_LATENCY, 3: ADC pipeline latency, in conversions (0..7).
- FIFO_DEPTH, 16: pair FIFO depth (power of 2, >= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run conversion; low = stop and flush the pairing logic
- clr_ovf  in  1  synchronous clear of ovf
- adc_input  in  ADC_WIDTH  ADC data bus
- adc_clk  out  1  ADC conversion clock
- adc_iq_sel  out  1  ADC channel select (1 = I, 0 = Q)
- tdata_m  out  2*OUT_WIDTH  {Q, I}; I occupies the low half
- tvalid_m  out  1  FIFO not empty
- tready_m  in  1  downstream ready
- ovf  out  1  sticky flag: a pair was dropped because the FIFO was full

Behaviour:
- Reset: all outputs and internal state go to 0 (adc_clk=0, adc_iq_sel=0, tvalid_m=0, tdata_m=0, ovf=0). FIFO is emptied. Reset asserted mid-operation aborts any partial pair.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable=1; adc_clk toggles on wrap. adc_clk period is 2*CLK_DIV clk cycles.
- Conversion event: the clk edge on which adc_clk is driven 1->0. On this edge:
  - adc_input is registered.
  - adc_iq_sel toggles; the first conversion after enable uses I (adc_iq_sel=1).
  - The current select value is shifted into sel_hist.
- Latency compensation: a sample captured at conversion n belongs to the channel held in sel_hist at depth ADC_LATENCY. The first ADC_LATENCY captures after enable rises are discarded (warm-up counter).
- Conversion to signed:
  - CODING=0: invert the MSB.
  - CODING=1: pass through.
  - Then left-justify: {code, (OUT_WIDTH-ADC_WIDTH) zeros}.
- Pairing FSM:
  - WAIT_I: an I sample stores the I half and moves to WAIT_Q; a Q sample is dropped.
  - WAIT_Q: a Q sample completes the pair; the pair is pushed and the FSM returns to WAIT_I.
  - Any enable deassertion returns the FSM to WAIT_I.
- Push timing: push occurs the cycle after the Q capture. tvalid_m rises the cycle after the push.
- Stream handshake:
  - A pop occurs on tvalid_m && tready_m.
  - tdata_m is stable while tvalid_m=1 and tready_m=0.
- FIFO full: push is rejected and ovf is set, unless a pop happens in the same cycle, in which case the push is accepted and the level is unchanged.
- FIFO empty: tvalid_m=0; tready_m is ignored.
- ovf clearing: clr_ovf clears ovf. If clr_ovf coincides with a new drop, set wins.
- enable=0:
  - adc_clk is driven 0 immediately (the half-period is truncated), div_cnt=0, adc_iq_sel=0.
  - sel_hist and warm-up counter are cleared.
  - FIFO contents are kept and continue to drain.

Optional Feature:
- Macro ADC_INPUT_OVF_COUNT_EN.
  - Defined: adds output port ovf_count (16 bits), a saturating count of dropped pairs, cleared by clr_ovf. A simultaneous drop and clear yields 1.
  - Undefined: no port and no counter. ovf still operates.

Decomposition:
- Package adc_input_pkg:
  - CODING_OFFSET_BIN=0 and CODING_TWOS_COMP=1 constants.
  - Pairing FSM state encodings WAIT_I and WAIT_Q.
  - Function for the MSB-invert/left-justify conversion.
- Sub-module adc_iq_fifo: synchronous show-ahead FIFO with push/pop/full/empty, parametrised by width and depth.

Test Plan:
- Coding check (ADC_WIDTH=10, OUT_WIDTH=16, CODING=0, ADC_LATENCY=0): inputs 10'h3FF / 10'h000 / 10'h200 -> I half 16'h7FC0 / 16'h8000 / 16'h0000. Repeat with CODING=1: input 10'h3FF -> 16'hFFC0.
- Latency and pairing (ADC_LATENCY=3, CLK_DIV=2): model returns the conversion-index value 3 conversions late.
  - First 3 captures are discarded.
  - Each tdata_m has I index even and Q index = I index + 1.
  - One pair is delivered every 8 clk.
- Backpressure (FIFO_DEPTH=4, tready_m=0 for 40 pairs):
  - tvalid_m stays 1 and tdata_m stays stable.
  - 4 pairs are held and ovf=1.
  - After tready_m=1, exactly those 4 pairs are delivered in order.
  - ovf_count=36 when ADC_INPUT_OVF_COUNT_EN is defined.
- Full plus simultaneous pop (FIFO full, tready_m=1, push cycle): no drop, ovf stays 0, level stays 4.
- Mid-pair abort: enable dropped after an I capture and before the Q capture.
  - adc_clk is 0 on the next cycle and no partial pair is emitted.
  - After re-enable, the first pair is a fresh I/Q pair after warm-up.
- Reset mid-stream: reset asserted with 3 pairs queued -> tvalid_m=0, adc_clk=0, ovf=0 with no clk edge required.

Source files
------------

// File: rtl/adc_input_pkg.sv
// Shared constants, pairing FSM encoding and sample conversion for the interleaved I/Q ADC front end.
package adc_input_pkg;

    localparam int unsigned CODING_OFFSET_BIN = 0;
    localparam int unsigned CODING_TWOS_COMP  = 1;
    localparam int unsigned OVF_CNT_W         = 16;
    localparam int unsigned WARM_W            = 3;

    typedef enum logic {
        WAIT_I = 1'b0,
        WAIT_Q = 1'b1
    } pair_state_e;

    // Offset binary becomes two's complement by flipping the MSB; the code is then left-justified.
    function automatic logic [31:0] to_signed_lj(
        input logic [31:0] code,
        input int unsigned adc_w,
        input int unsigned out_w,
        input int unsigned coding
    );
        logic [31:0] c;
        c = code;
        if (coding == CODING_OFFSET_BIN) begin
            c = c ^ (32'd1 << (adc_w - 1));
        end
        return c << (out_w - adc_w);
    endfunction

endpackage

// File: rtl/adc_iq_fifo.sv
// Synchronous show-ahead FIFO; pop_data always presents the oldest entry while valid is high.
module adc_iq_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = pop && valid_q;
        do_push  = push && (!full_q || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign valid    = valid_q;
    assign full     = full_q;

endmodule

// File: rtl/adc_input_iq.sv
// Interleaved I/Q ADC front end: conversion clock, latency-compensated channel pairing, pair FIFO, AXI-Stream out.
// Define ADC_INPUT_OVF_COUNT_EN to add the saturating ovf_count output.
module adc_input_iq
    import adc_input_pkg::*;
#(
    parameter int unsigned ADC_WIDTH   = 10,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned CODING      = 0,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned ADC_LATENCY = 3,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clr_ovf,
    input  logic [ADC_WIDTH-1:0]   adc_input,
    output logic                   adc_clk,
    output logic                   adc_iq_sel,
    output logic [2*OUT_WIDTH-1:0] tdata_m,
    output logic                   tvalid_m,
    input  logic                   tready_m,
`ifdef ADC_INPUT_OVF_COUNT_EN
    output logic [OVF_CNT_W-1:0]   ovf_count,
`endif
    output logic                   ovf
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HIST_W = (ADC_LATENCY > 0) ? ADC_LATENCY : 1;
    localparam int unsigned PAIR_W = 2 * OUT_WIDTH;

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 adc_clk_q, adc_clk_d;
    logic                 iq_sel_q, iq_sel_d;
    logic [HIST_W-1:0]    sel_hist_q, sel_hist_d;
    logic [WARM_W-1:0]    warm_q, warm_d;
    pair_state_e          state_q, state_d;
    logic [OUT_WIDTH-1:0] i_half_q, i_half_d;
    logic [PAIR_W-1:0]    pair_q, pair_d;
    logic                 push_q, push_d;
    logic                 ovf_q, ovf_d;

    logic                 div_wrap;
    logic                 conv_evt;
    logic                 sel_new;
    logic [HIST_W:0]      hist_shift;
    logic                 samp_is_i;
    logic                 samp_ok;
    logic [OUT_WIDTH-1:0] samp_lj;
    logic                 fifo_valid, fifo_full, fifo_pop, drop;
    logic [PAIR_W-1:0]    fifo_data;

    // A conversion is the edge that drives adc_clk from 1 to 0; the oldest history bit names the sample's channel.
    always_comb begin
        div_wrap   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        conv_evt   = enable && div_wrap && adc_clk_q;
        sel_new    = ~iq_sel_q;
        hist_shift = {sel_hist_q, sel_new};
        samp_is_i  = hist_shift[ADC_LATENCY];
        samp_ok    = conv_evt && (warm_q == WARM_W'(ADC_LATENCY));
        samp_lj    = OUT_WIDTH'(to_signed_lj(32'(adc_input), ADC_WIDTH, OUT_WIDTH, CODING));
    end

    always_comb begin
        div_cnt_d  = div_cnt_q;
        adc_clk_d  = adc_clk_q;
        iq_sel_d   = iq_sel_q;
        sel_hist_d = sel_hist_q;
        warm_d     = warm_q;
        state_d    = state_q;
        i_half_d   = i_half_q;
        pair_d     = pair_q;
        push_d     = 1'b0;
        if (!enable) begin
            div_cnt_d  = '0;
            adc_clk_d  = 1'b0;
            iq_sel_d   = 1'b0;
            sel_hist_d = '0;
            warm_d     = '0;
            state_d    = WAIT_I;
        end else begin
            if (div_wrap) begin
                div_cnt_d = '0;
                adc_clk_d = ~adc_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            if (conv_evt) begin
                iq_sel_d   = sel_new;
                sel_hist_d = hist_shift[HIST_W-1:0];
                if (!samp_ok) begin
                    warm_d = warm_q + WARM_W'(1);
                end
            end
            if (samp_ok) begin
                case (state_q)
                    WAIT_I: begin
                        if (samp_is_i) begin
                            i_half_d = samp_lj;
                            state_d  = WAIT_Q;
                        end
                    end
                    WAIT_Q: begin
                        // A repeated I restarts the pair rather than pairing across a gap.
                        if (samp_is_i) begin
                            i_half_d = samp_lj;
                        end else begin
                            pair_d  = {samp_lj, i_half_q};
                            push_d  = 1'b1;
                            state_d = WAIT_I;
                        end
                    end
                    default: state_d = WAIT_I;
                endcase
            end
        end
    end

    always_comb begin
        fifo_pop = fifo_valid && tready_m;
        drop     = push_q && fifo_full && !fifo_pop;
        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q  <= '0;
            adc_clk_q  <= 1'b0;
            iq_sel_q   <= 1'b0;
            sel_hist_q <= '0;
            warm_q     <= '0;
            state_q    <= WAIT_I;
            i_half_q   <= '0;
            pair_q     <= '0;
            push_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            adc_clk_q  <= adc_clk_d;
            iq_sel_q   <= iq_sel_d;
            sel_hist_q <= sel_hist_d;
            warm_q     <= warm_d;
            state_q    <= state_d;
            i_half_q   <= i_half_d;
            pair_q     <= pair_d;
            push_q     <= push_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef ADC_INPUT_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating drop counter; a drop in the clearing cycle leaves a count of one.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_ovf) begin
            ovf_cnt_d = drop ? OVF_CNT_W'(1) : '0;
        end else if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    adc_iq_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (pair_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .valid     (fifo_valid),
        .full      (fifo_full)
    );

    assign adc_clk    = adc_clk_q;
    assign adc_iq_sel = iq_sel_q;
    assign tdata_m    = fifo_data;
    assign tvalid_m   = fifo_valid;
    assign ovf        = ovf_q;

endmodule
